// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
//   Drains rows of 8 x 32-bit signed accumulators out of a source BRAM, turns
//   each lane into a saturated int8 and writes the packed 64-bit row into a
//   destination BRAM.
//
//   The block issues one read per cycle, and a valid/address pipeline follows
//   the BRAM read latency. Each returning row is then written one cycle after
//   its data is valid.
//
//   Requantization: each lane is shifted right arithmetically by `shift`, at
//   33-bit width, and then saturated to [-128,127].
//     RESULT_DRAIN_ROUND_EN undefined : the shift truncates toward -inf.
//     RESULT_DRAIN_ROUND_EN defined   : 2^(shift-1) is added first (round half
//                                       up). It is not added when shift == 0.
//
// Parameters
//   BRAM_DELAY  source read latency in cycles (1..4)
//   ROWS_LEN    address width of the source and destination BRAMs
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start                 drain request (sampled only in IDLE, not with done)
//   row_count[ROWS_LEN:0] rows to drain, 0..2^ROWS_LEN
//   shift[4:0]            right-shift amount
//   busy, done            status: busy until done inclusive; done is a 1-cycle pulse
//   src_addr/src_en       source read port
//   src_dout[255:0]       source read data, BRAM_DELAY cycles after its address
//   dst_addr/dst_din/dst_we destination write port (packed int8 x 8)
// -----------------------------------------------------------------------------
module result_drain #(
  parameter int BRAM_DELAY = 1,
  parameter int ROWS_LEN   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ROWS_LEN:0]   row_count,
  input  logic [4:0]          shift,
  output logic                busy,
  output logic                done,
  output logic [ROWS_LEN-1:0] src_addr,
  input  logic [255:0]        src_dout,
  output logic                src_en,
  output logic [ROWS_LEN-1:0] dst_addr,
  output logic [63:0]         dst_din,
  output logic                dst_we
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, FIN} state_t;

  state_t              state;
  logic [ROWS_LEN:0]   rows_q;
  logic [ROWS_LEN:0]   rows_last;
  logic [4:0]          shift_q;
  logic [63:0]         packed_row;
  logic                last_ret;

  // The valid bit and the row index for each read in flight.
  logic [BRAM_DELAY-1:0] pipe_v;
  logic [ROWS_LEN-1:0]   pipe_a [BRAM_DELAY];

  // Converts one 32-bit signed lane to a saturated int8.
  function automatic logic [7:0] requant(input logic signed [31:0] lane,
                                         input logic [4:0] sh);
    logic signed [32:0] wide;
    wide = {lane[31], lane};
`ifdef RESULT_DRAIN_ROUND_EN
    if (sh != 5'd0) wide = wide + (33'sd1 <<< (sh - 5'd1));
`endif
    wide = wide >>> sh;
    if (wide > 33'sd127)       return 8'h7F;
    else if (wide < -33'sd128) return 8'h80;
    else                       return wide[7:0];
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so that
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    packed_row = '0;
    for (int i = 0; i < 8; i++)
      packed_row[8*i +: 8] = requant($signed(src_dout[32*i +: 32]), shift_q);
  end

  assign rows_last = rows_q - 1'b1;
  // The last row's data is at the pipeline output, so its write lands next cycle.
  assign last_ret  = pipe_v[BRAM_DELAY-1] &&
                     ({1'b0, pipe_a[BRAM_DELAY-1]} == rows_last);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= src_en;
      for (int i = 1; i < BRAM_DELAY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // NOTE: the address pipeline has no reset. Each entry is qualified by
  // pipe_v, and pipe_v is cleared.
  always_ff @(posedge clk) begin
    pipe_a[0] <= src_addr;
    for (int i = 1; i < BRAM_DELAY; i++) pipe_a[i] <= pipe_a[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      src_en   <= 1'b0;
      src_addr <= '0;
      dst_we   <= 1'b0;
      dst_addr <= '0;
      dst_din  <= '0;
      rows_q   <= '0;
      shift_q  <= '0;
    end else begin
      dst_we <= pipe_v[BRAM_DELAY-1];
      if (pipe_v[BRAM_DELAY-1]) begin
        dst_addr <= pipe_a[BRAM_DELAY-1];
        dst_din  <= packed_row;
      end
      done <= 1'b0;

      case (state)
        IDLE: begin
          // The done pulse occurs while in IDLE. A start in that cycle is dropped.
          if (start && !done) begin
            busy    <= 1'b1;
            rows_q  <= row_count;
            shift_q <= shift;
            if (row_count == '0) begin
              state <= FIN;
            end else begin
              state    <= ISSUE;
              src_en   <= 1'b1;
              src_addr <= '0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          // The compare is one bit wider than the address, so 2^ROWS_LEN rows
          // end at the all-ones address instead of wrapping.
          if ({1'b0, src_addr} == rows_last) begin
            src_en   <= 1'b0;
            src_addr <= '0;
            state    <= FLUSH;
          end else begin
            src_addr <= src_addr + 1'b1;
          end
        end
        FLUSH: begin
          if (last_ret) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// -----------------------------------------------------------------------------
// tb_result_drain
//   Runs two result_drain instances from the same stimulus: one with
//   BRAM_DELAY=1 and one with BRAM_DELAY=3. Each instance has a BRAM model.
//
//   A per-instance model records each accepted start (cycle T, row_count and
//   shift). On every cycle it derives from cycle offsets which outputs must be
//   active, together with the expected addresses and packed data. Literal
//   checks pin the key timing and data values by hand.
// -----------------------------------------------------------------------------
module tb_result_drain;

  localparam int RL = 10;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [RL:0] row_count;
  logic [4:0]  shift;

  logic [1:0]    busy_w, done_w, src_en_w, dst_we_w;
  logic [RL-1:0] src_addr_w [2];
  logic [RL-1:0] dst_addr_w [2];
  logic [63:0]   dst_din_w  [2];
  logic [255:0]  src_dout_w [2];

  logic [255:0] mem [1024];

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt, done_cnt, en_cnt;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected packed int8 row, computed with plain integer arithmetic.
  function automatic logic [63:0] model_row(input logic [255:0] row, input int sh);
    logic [63:0] r;
    longint v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v = longint'($signed(row[32*i +: 32]));
`ifdef RESULT_DRAIN_ROUND_EN
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
      v = v >>> sh;            // floor division by 2^sh
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      r[8*i +: 8] = v[7:0];
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 1 : 3;
    logic [RL-1:0] ap [D];

    // Source BRAM model: the data for an address appears D cycles later.
    always @(posedge clk) begin
      ap[0] <= src_addr_w[g];
      for (int i = 1; i < D; i++) ap[i] <= ap[i-1];
    end
    assign src_dout_w[g] = mem[ap[D-1]];

    result_drain #(.BRAM_DELAY(D), .ROWS_LEN(RL)) dut (
      .clk(clk), .rst(rst), .start(start), .row_count(row_count), .shift(shift),
      .busy(busy_w[g]), .done(done_w[g]), .src_addr(src_addr_w[g]),
      .src_dout(src_dout_w[g]), .src_en(src_en_w[g]), .dst_addr(dst_addr_w[g]),
      .dst_din(dst_din_w[g]), .dst_we(dst_we_w[g])
    );

    int cyc = 0;
    bit act = 0;
    bit zero_chk = 0;
    bit started = 0;
    int t0, mrc, msh;

    function automatic int end_k(input int rc);
      return (rc == 0) ? 2 : 2 + D + rc;
    endfunction

    // Model update: the inputs of cycle cyc are sampled at the edge that ends it.
    always @(posedge clk) begin
      started  = 1;
      zero_chk = rst;
      if (rst) begin
        act = 0;
      end else if (start && (!act || (cyc - t0) > end_k(mrc))) begin
        act = 1;
        t0  = cyc;
        mrc = int'(row_count);
        msh = int'(shift);
      end
      cyc++;
    end

    // Compare all outputs against the model in the middle of every cycle.
    always @(negedge clk) begin
      if (started) begin
        int k;
        bit e_busy, e_done, e_en, e_we;
        k      = cyc - t0;
        e_busy = act && k >= 1 && k <= end_k(mrc);
        e_done = act && k == end_k(mrc);
        e_en   = act && k >= 1 && k <= mrc;
        e_we   = act && k >= D + 2 && k <= D + 1 + mrc;
        check($sformatf("busy[%0d]", g),   64'(busy_w[g]),   64'(e_busy));
        check($sformatf("done[%0d]", g),   64'(done_w[g]),   64'(e_done));
        check($sformatf("src_en[%0d]", g), 64'(src_en_w[g]), 64'(e_en));
        check($sformatf("dst_we[%0d]", g), 64'(dst_we_w[g]), 64'(e_we));
        if (e_en)
          check($sformatf("src_addr[%0d]", g), 64'(src_addr_w[g]), 64'(k - 1));
        if (e_we) begin
          check($sformatf("dst_addr[%0d]", g), 64'(dst_addr_w[g]), 64'(k - D - 2));
          check($sformatf("dst_din[%0d]", g), dst_din_w[g], model_row(mem[k - D - 2], msh));
        end
        if (zero_chk) begin
          check($sformatf("rst_src_addr[%0d]", g), 64'(src_addr_w[g]), 64'd0);
          check($sformatf("rst_dst_addr[%0d]", g), 64'(dst_addr_w[g]), 64'd0);
          check($sformatf("rst_dst_din[%0d]", g),  dst_din_w[g],       64'd0);
        end
      end
    end
  end

  // Event counters for instance 0 (BRAM_DELAY=1).
  always @(negedge clk) begin
    if (dst_we_w[0])   we_cnt++;
    if (done_w[0])     done_cnt++;
    if (src_en_w[0])   en_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_cnt();
    we_cnt = 0; done_cnt = 0; en_cnt = 0;
  endtask

  // Drives start for exactly one cycle (cycle T). Returns in cycle T+1.
  task automatic pulse(input int rc, input int sh);
    start     = 1'b1;
    row_count = (RL+1)'(rc);
    shift     = 5'(sh);
    tick(1);
    start = 1'b0;
  endtask

  function automatic logic [255:0] mk_row(input int l0, l1, l2, l3, l4, l5, l6, l7);
    logic [255:0] r;
    r = {32'(l7), 32'(l6), 32'(l5), 32'(l4), 32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 1024; i++)
      for (int j = 0; j < 8; j++)
        mem[i][32*j +: 32] = (j < 4) ? $urandom() : 32'($signed($urandom_range(0, 4000)) - 2000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_count = '0; shift = '0;
    fill_random();
    tick(3);
    check("reset_busy", 64'(busy_w), 64'd0);
    check("reset_dst_we", 64'(dst_we_w), 64'd0);
    rst = 1'b0;
    tick(2);

    // Three rows with saturation corner lanes and shift=0.
    for (int i = 0; i < 3; i++) mem[i] = mk_row(5, -5, 127, 128, -128, -129, 0, 1);
    clr_cnt();
    pulse(3, 0);                                    // now in T+1
    tick(2);                                        // T+3
    check("first_we_T3", 64'(dst_we_w[0]), 64'd1);
    check("bytes_T3", dst_din_w[0], 64'h01008080_7F7FFB05);
    tick(2);                                        // T+5
    check("addr_T5", 64'(dst_addr_w[0]), 64'd2);
    check("d3_first_we_T5", 64'(dst_we_w[1]), 64'd1);
    check("d3_first_addr_T5", 64'(dst_addr_w[1]), 64'd0);
    tick(1);                                        // T+6
    check("done_T6", 64'(done_w[0]), 64'd1);
    tick(8);
    check("writes_rc3", 64'(we_cnt), 64'd3);

    // Rounding corner cases with shift=4.
    mem[0] = mk_row(24, -24, 0, 0, 0, 0, 0, 0);
    pulse(1, 4);
    tick(2);                                        // T+3
`ifdef RESULT_DRAIN_ROUND_EN
    check("round_24_m24", 64'(dst_din_w[0][15:0]), 64'h0000_0000_0000_FF02);
`else
    check("trunc_24_m24", 64'(dst_din_w[0][15:0]), 64'h0000_0000_0000_FE01);
`endif
    tick(10);

    // Zero rows: no reads, no writes, done at T+2.
    clr_cnt();
    pulse(0, 0);                                    // T+1
    check("rc0_busy_T1", 64'(busy_w[0]), 64'd1);
    check("rc0_nodone_T1", 64'(done_w[0]), 64'd0);
    tick(1);                                        // T+2
    check("rc0_done_T2", 64'(done_w[0]), 64'd1);
    tick(1);
    check("rc0_idle_T3", 64'(busy_w[0]), 64'd0);
    tick(5);
    check("rc0_no_en", 64'(en_cnt), 64'd0);
    check("rc0_no_we", 64'(we_cnt), 64'd0);
    check("rc0_one_done", 64'(done_cnt), 64'd1);

    // Full depth: 1024 rows.
    fill_random();
    clr_cnt();
    pulse(1024, 3);
    tick(1040);
    check("full_writes", 64'(we_cnt), 64'd1024);
    check("full_done", 64'(done_cnt), 64'd1);

    // Abort: rst is asserted in cycle T+5 of a 10-row drain.
    clr_cnt();
    pulse(10, 2);                                   // T+1
    tick(4);                                        // T+5
    rst = 1'b1;
    tick(1);                                        // T+6
    check("abort_busy", 64'(busy_w), 64'd0);
    check("abort_we", 64'(dst_we_w), 64'd0);
    check("abort_en", 64'(src_en_w), 64'd0);
    rst = 1'b0;
    tick(15);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_writes", 64'(we_cnt), 64'd3);
    pulse(4, 1);
    tick(12);
    check("after_abort_done", 64'(done_cnt), 64'd1);
    check("after_abort_writes", 64'(we_cnt), 64'd7);

    // A start while busy is ignored, and so are new inputs.
    clr_cnt();
    pulse(5, 0);                                    // T+1
    tick(1);                                        // T+2
    start = 1'b1; row_count = 11'd9; shift = 5'd7;
    tick(1);
    start = 1'b0;
    tick(15);
    check("busy_start_writes", 64'(we_cnt), 64'd5);
    check("busy_start_done", 64'(done_cnt), 64'd1);

    // A start that coincides with done is ignored.
    clr_cnt();
    pulse(2, 0);                                    // T+1
    tick(4);                                        // T+5 (done)
    check("coincide_done", 64'(done_w[0]), 64'd1);
    start = 1'b1; row_count = 11'd3;
    tick(1);
    start = 1'b0;
    tick(12);
    check("coincide_writes", 64'(we_cnt), 64'd2);

    // Random drains, with the inputs changing while each drain runs.
    fill_random();
    for (int r = 0; r < 6; r++) begin
      pulse($urandom_range(1, 20), $urandom_range(0, 31));
      for (int c = 0; c < 32; c++) begin
        row_count = (RL+1)'($urandom_range(0, 1024));
        shift     = 5'($urandom_range(0, 31));
        tick(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
